// File: rtl/sipo_deframer_if.sv
// Bundle between the sipo_deframer and its neighbours: the serial input side
// coming from the PISO and the parallel valid/ready output side with status flags.
interface sipo_deframer_if #(
  parameter int WIDTH = 4
);
  logic             in_sd;
  logic             in_sv;
  logic             in_sync;
  logic             in_ready;
  logic             in_clr;
  logic [WIDTH-1:0] o_data;
  logic             o_valid;
  logic             o_ovf;
  logic             o_resync;
  logic             o_perr;

  // The master drives the serial stream and consumes words; the slave is the deframer
  modport master (
    output in_sd, in_sv, in_sync, in_ready, in_clr,
    input  o_data, o_valid, o_ovf, o_resync, o_perr
  );

  modport slave (
    input  in_sd, in_sv, in_sync, in_ready, in_clr,
    output o_data, o_valid, o_ovf, o_resync, o_perr
  );
endinterface

// File: rtl/sipo_deframer.sv
// LSB-first serial-to-parallel deframer with start-marker framing, a one-word
// valid/ready holding buffer and sticky ovf/resync/perr flags. Define SIPO_PARITY_EN for even parity.
module sipo_deframer #(
  parameter int WIDTH = 4
) (
  input logic             in_clk,
  input logic             in_rst,
  sipo_deframer_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);
`ifdef SIPO_PARITY_EN
  localparam int LAST = WIDTH;
`else
  localparam int LAST = WIDTH - 1;
`endif

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] data_q;
  logic             valid_q;
  logic             ovf_q;
  logic             resync_q;

  logic [WIDTH-1:0] word_next;
  logic             accept;
  logic             final_bit;
  logic             word_done;
  logic             resync_set;
  logic             ovf_set;
  logic             load;

`ifdef SIPO_PARITY_EN
  logic perr_q;
  logic perr_set;
`endif

  // word_next is the shifter contents with the current bit inserted at position cnt;
  // on the parity bit cnt==WIDTH matches no position, so it is just the data word
  always_comb begin
    word_next = shreg;
    for (int i = 0; i < WIDTH; i++) begin
      if (cnt == CNT_W'(i)) word_next[i] = bus.in_sd;
    end
    accept     = (state == SHIFT) && bus.in_sv && !bus.in_sync;
    final_bit  = accept && (cnt == CNT_W'(LAST));
    resync_set = (state == SHIFT) && bus.in_sv && bus.in_sync;
`ifdef SIPO_PARITY_EN
    word_done  = final_bit && ((^shreg ^ bus.in_sd) == 1'b0);
    perr_set   = final_bit && ((^shreg ^ bus.in_sd) == 1'b1);
`else
    word_done  = final_bit;
`endif
    load       = word_done && (!valid_q || bus.in_ready);
    ovf_set    = word_done && valid_q && !bus.in_ready;
  end

  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      state    <= IDLE;
      cnt      <= '0;
      shreg    <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
      resync_q <= 1'b0;
`ifdef SIPO_PARITY_EN
      perr_q   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_sv && bus.in_sync) begin
            shreg <= WIDTH'(bus.in_sd);
            cnt   <= CNT_W'(1);
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (resync_set) begin
            shreg <= WIDTH'(bus.in_sd);
            cnt   <= CNT_W'(1);
          end else if (final_bit) begin
            shreg <= '0;
            cnt   <= '0;
            state <= IDLE;
          end else if (accept) begin
            shreg <= word_next;
            cnt   <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase

      // A word loading on a transfer edge keeps o_valid high without a gap
      if (load) begin
        data_q  <= word_next;
        valid_q <= 1'b1;
      end else if (valid_q && bus.in_ready) begin
        valid_q <= 1'b0;
      end

      ovf_q    <= ovf_set    || (ovf_q    && !bus.in_clr);
      resync_q <= resync_set || (resync_q && !bus.in_clr);
`ifdef SIPO_PARITY_EN
      perr_q   <= perr_set   || (perr_q   && !bus.in_clr);
`endif
    end
  end

  assign bus.o_data   = data_q;
  assign bus.o_valid  = valid_q;
  assign bus.o_ovf    = ovf_q;
  assign bus.o_resync = resync_q;
`ifdef SIPO_PARITY_EN
  assign bus.o_perr   = perr_q;
`else
  assign bus.o_perr   = 1'b0;
`endif

endmodule

// File: tb/tb_sipo_deframer.sv
// Directed self-checking bench for sipo_deframer (WIDTH=4), covering reset,
// stalls, overrun, simultaneous transfer/load, resync and optional parity.
module tb_sipo_deframer;

  logic in_clk;
  logic in_rst;
  int   tests_run;
  int   tests_failed;

  sipo_deframer_if #(.WIDTH(4)) bus ();

  sipo_deframer #(.WIDTH(4)) dut (
    .in_clk (in_clk),
    .in_rst (in_rst),
    .bus    (bus)
  );

  initial begin
    in_clk = 1'b0;
    forever #5 in_clk = ~in_clk;
  end

  // Every comparison funnels through here so the counters stay honest
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of serial inputs, then return 1 time unit after the sampling edge
  task automatic applyStimulus(input logic sv, input logic sync, input logic sd);
    bus.in_sv   = sv;
    bus.in_sync = sync;
    bus.in_sd   = sd;
    @(posedge in_clk);
    #1;
    bus.in_sv   = 1'b0;
    bus.in_sync = 1'b0;
    bus.in_sd   = 1'b0;
  endtask

  task automatic sendFrame(input logic [3:0] word);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, (i == 0), word[i]);
  endtask

  task automatic checkFlags(input string tag, input logic ovf, input logic resync, input logic perr);
    checkOutput({tag, "_ovf"}, {31'd0, bus.o_ovf}, {31'd0, ovf});
    checkOutput({tag, "_resync"}, {31'd0, bus.o_resync}, {31'd0, resync});
    checkOutput({tag, "_perr"}, {31'd0, bus.o_perr}, {31'd0, perr});
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    bus.in_sd    = 1'b0;
    bus.in_sv    = 1'b0;
    bus.in_sync  = 1'b0;
    bus.in_ready = 1'b0;
    bus.in_clr   = 1'b0;
    in_rst       = 1'b0;
    #12;
    checkOutput("rst_data", 32'(bus.o_data), 32'h0);
    checkOutput("rst_valid", {31'd0, bus.o_valid}, 32'h0);
    checkFlags("rst", 1'b0, 1'b0, 1'b0);
    @(negedge in_clk);
    in_rst = 1'b1;
    @(posedge in_clk);
    #1;

    // Reset mid-word while a word is held and a new one is half-received
    bus.in_ready = 1'b0;
    sendFrame(4'hA);
    checkOutput("pre_rst_valid", {31'd0, bus.o_valid}, 32'h1);
    applyStimulus(1'b1, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    #2;
    in_rst = 1'b0;
    #1;
    checkOutput("async_rst_data", 32'(bus.o_data), 32'h0);
    checkOutput("async_rst_valid", {31'd0, bus.o_valid}, 32'h0);
    #1;
    in_rst = 1'b1;
    bus.in_ready = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("post_rst_3bits_valid", {31'd0, bus.o_valid}, 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b1);
    checkOutput("post_rst_data", 32'(bus.o_data), 32'hB);
    checkOutput("post_rst_valid", {31'd0, bus.o_valid}, 32'h1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("post_rst_xfer_valid", {31'd0, bus.o_valid}, 32'h0);

    // Stalls of three cycles between bits, with in_sync waggled while in_sv=0
    begin
      logic [3:0] stall_word;
      stall_word = 4'h6;
      for (int i = 0; i < 4; i++) begin
        applyStimulus(1'b1, (i == 0), stall_word[i]);
        if (i < 3) begin
          for (int g = 0; g < 3; g++) applyStimulus(1'b0, 1'b1, 1'b1);
          checkOutput("stall_gap_valid", {31'd0, bus.o_valid}, 32'h0);
        end
      end
    end
    checkOutput("stall_data", 32'(bus.o_data), 32'h6);
    checkOutput("stall_valid", {31'd0, bus.o_valid}, 32'h1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("stall_pulse_end", {31'd0, bus.o_valid}, 32'h0);
    checkFlags("stall", 1'b0, 1'b0, 1'b0);

    // Overrun: second back-to-back word is dropped while the first is held
    bus.in_ready = 1'b0;
    sendFrame(4'hA);
    checkOutput("ovr_first_data", 32'(bus.o_data), 32'hA);
    checkOutput("ovr_first_ovf", {31'd0, bus.o_ovf}, 32'h0);
    sendFrame(4'h5);
    checkOutput("ovr_held_data", 32'(bus.o_data), 32'hA);
    checkOutput("ovr_ovf", {31'd0, bus.o_ovf}, 32'h1);
    bus.in_ready = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("ovr_xfer_valid", {31'd0, bus.o_valid}, 32'h0);
    checkOutput("ovr_ovf_sticky", {31'd0, bus.o_ovf}, 32'h1);
    bus.in_clr = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0);
    bus.in_clr = 1'b0;
    checkOutput("ovr_clr", {31'd0, bus.o_ovf}, 32'h0);

    // Transfer of 4'h3 and load of 4'hC on the same edge
    bus.in_ready = 1'b0;
    sendFrame(4'h3);
    checkOutput("simul_first_data", 32'(bus.o_data), 32'h3);
    applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1);
    bus.in_ready = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b1);
    checkOutput("simul_data", 32'(bus.o_data), 32'hC);
    checkOutput("simul_valid", {31'd0, bus.o_valid}, 32'h1);
    checkOutput("simul_ovf", {31'd0, bus.o_ovf}, 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("simul_drain", {31'd0, bus.o_valid}, 32'h0);

    // Resync: a partial 1,0 is abandoned when a new marker arrives
    applyStimulus(1'b1, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("resync_before", {31'd0, bus.o_resync}, 32'h0);
    sendFrame(4'hF);
    checkOutput("resync_flag", {31'd0, bus.o_resync}, 32'h1);
    checkOutput("resync_data", 32'(bus.o_data), 32'hF);
    applyStimulus(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b0, 1'b1);
    checkOutput("idle_nosync_valid", {31'd0, bus.o_valid}, 32'h0);
    sendFrame(4'h2);
    checkOutput("after_idle_data", 32'(bus.o_data), 32'h2);

    // Clear loses to a resync event on the same edge
    bus.in_clr = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0);
    bus.in_clr = 1'b0;
    checkOutput("resync_clr", {31'd0, bus.o_resync}, 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    bus.in_clr = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b1);
    bus.in_clr = 1'b0;
    checkOutput("clr_vs_set", {31'd0, bus.o_resync}, 32'h1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1);
    checkOutput("clr_vs_set_data", 32'(bus.o_data), 32'h9);

`ifdef SIPO_PARITY_EN
    // Parity frames: data 1,0,1,1 then the parity bit
    bus.in_clr = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0);
    bus.in_clr = 1'b0;
    sendFrame(4'hD);
    checkOutput("par_no_early_valid", {31'd0, bus.o_valid}, 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b1);
    checkOutput("par_ok_data", 32'(bus.o_data), 32'hD);
    checkOutput("par_ok_valid", {31'd0, bus.o_valid}, 32'h1);
    checkOutput("par_ok_perr", {31'd0, bus.o_perr}, 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    sendFrame(4'hD);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("par_bad_valid", {31'd0, bus.o_valid}, 32'h0);
    checkOutput("par_bad_perr", {31'd0, bus.o_perr}, 32'h1);
    checkOutput("par_bad_ovf", {31'd0, bus.o_ovf}, 32'h0);
`else
    checkOutput("perr_tied", {31'd0, bus.o_perr}, 32'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/sipo_deframer.md
# sipo_deframer

Serial-in, parallel-out receive stage sitting directly downstream of the team's 4-bit PISO shift register. It collects the LSB-first serial stream (bit 0 of the loaded word leaves the PISO first) into a WIDTH-bit word, framed by a start marker. It presents each completed word on a registered valid/ready output with one-word holding buffer, and flags overruns and resynchronisations.

## Interface
- WIDTH, 4, data bits per word (2..16)
- in_clk  input  1  rising-edge clock
- in_rst  input  1  asynchronous reset, active-low
- in_sd  input  1  serial data bit
- in_sv  input  1  serial valid; in_sd is sampled only on edges where in_sv=1
- in_sync  input  1  frame marker, qualified by in_sv; marks the current bit as bit 0 of a new word
- in_ready  input  1  downstream ready for o_data
- in_clr  input  1  synchronous clear of sticky flags
- o_data  output  WIDTH  completed word, bit i = i-th serial bit received
- o_valid  output  1  o_data holds an unconsumed word
- o_ovf  output  1  sticky: completed word dropped because buffer full
- o_resync  output  1  sticky: in_sync arrived mid-word, partial word discarded
- o_perr  output  1  sticky parity error (0 unless SIPO_PARITY_EN)

## Operation
- States: IDLE (waiting for frame) and SHIFT (collecting); bit counter cnt, 0..WIDTH-1 (0..WIDTH with parity).
- IDLE: in_sv=1 & in_sync=1 -> store in_sd as bit 0, cnt=1, go SHIFT. in_sv=1 & in_sync=0 -> bit discarded. in_sv=0 -> no change regardless of in_sync.
- SHIFT: in_sv=1 & in_sync=0 -> store in_sd at position cnt, cnt+1. in_sv=0 -> hold (stall, any length).
- SHIFT with in_sv=1 & in_sync=1 before word complete -> discard partial word, set o_resync, treat bit as bit 0 (cnt=1, stay SHIFT).
- Word complete on edge accepting the final bit -> state IDLE, cnt=0, word offered to buffer.
- Buffer: o_valid=0, or o_valid=1 & in_ready=1 in the completion cycle -> o_data=word, o_valid=1. o_valid=1 & in_ready=0 -> word dropped, o_ovf set, o_data unchanged.
- Handshake: transfer occurs on an edge with o_valid=1 & in_ready=1; o_valid falls next cycle unless a new word loads on the same edge. o_data stable while o_valid=1 & in_ready=0.
- in_clr=1 clears o_ovf, o_resync, o_perr; a set event on the same edge wins (flag stays 1).

## Timing
- Reset (in_rst=0, asynchronous, any state): IDLE, cnt=0, o_data=0, o_valid=0, o_ovf=0, o_resync=0, o_perr=0. Partial word lost; release takes effect on next edge.
- Latency: o_valid=1 in the cycle after the edge that samples the last bit.
- Back-to-back: in_sync with bit 0 of the next word accepted on the edge immediately after the last bit; full throughput one bit per cycle.
- in_ready has no effect on the serial side; the shifter never stalls upstream.

## Configuration
- SIPO_PARITY_EN defined: each frame carries one extra even-parity bit after bit WIDTH-1 (XOR of data bits and parity bit must be 0). Word completes on the parity bit edge. Mismatch -> word dropped (not offered to buffer, no o_ovf), o_perr set.
- Undefined: frames are exactly WIDTH bits, no parity logic, o_perr tied to 0.

## Test plan
- Reset mid-word: after 2 bits, pulse in_rst=0 -> all outputs 0 immediately; next frame 1,1,0,1 (sync on first) yields o_data=4'hB, o_valid=1 one cycle after 4th bit.
- Stalls: frame 0,1,1,0 with in_sv=0 gaps of 3 cycles between bits, in_ready=1 -> o_data=4'h6, one-cycle o_valid pulse, no flags.
- Overrun: in_ready=0, frames 4'hA then 4'h5 back-to-back -> o_data stays 4'hA, o_ovf=1; in_ready=1 -> transfer, o_valid=0; in_clr=1 -> o_ovf=0.
- Simultaneous: o_valid=1 with 4'h3, in_ready=1 on the completion edge of 4'hC -> o_data=4'hC, o_valid stays 1, o_ovf=0.
- Resync: bits 1,0 then in_sync with 1,1,1,1 -> o_resync=1, o_data=4'hF; bits with in_sv=1 in IDLE and no sync -> ignored, o_valid stays 0.
- SIPO_PARITY_EN: 1,0,1,1 + parity 1 -> o_data=4'hD; same data + parity 0 -> no o_valid, o_perr=1.
